// File: rtl/ring_tap_pkg.sv
// Shared constants for the ring tap: packet control codes, word field positions
// and one-hot state encoding.
package ring_tap_pkg;

  localparam int PCC_W      = 2;
  localparam logic [PCC_W-1:0] PCC_DATA   = 2'd0;
  localparam logic [PCC_W-1:0] PCC_SOP    = 2'd1;
  localparam logic [PCC_W-1:0] PCC_EOP    = 2'd2;
  localparam logic [PCC_W-1:0] PCC_BADEOP = 2'd3;

  localparam int DEF_PDP_SZ = 64;
  localparam int DEF_RDP_SZ = DEF_PDP_SZ + 1;
  localparam int PVEC_BIT   = DEF_RDP_SZ - 1;
  localparam int PCC_LSB    = DEF_PDP_SZ - PCC_W;

  localparam int ST_IDLE  = 0;
  localparam int ST_TDATA = 1;
  localparam int ST_TDROP = 2;
  localparam int ST_RFWD  = 3;
  localparam int ST_RCOPY = 4;
  localparam int ST_RSINK = 5;

  typedef enum logic [5:0] {
    S_IDLE  = 6'(1 << ST_IDLE),
    S_TDATA = 6'(1 << ST_TDATA),
    S_TDROP = 6'(1 << ST_TDROP),
    S_RFWD  = 6'(1 << ST_RFWD),
    S_RCOPY = 6'(1 << ST_RCOPY),
    S_RSINK = 6'(1 << ST_RSINK)
  } state_t;

  function automatic logic is_end_pcc(input logic [PCC_W-1:0] pcc);
    return (pcc == PCC_EOP) || (pcc == PCC_BADEOP);
  endfunction

endpackage

// File: rtl/ring_tap_fair_fsm_stats.sv
// Packet statistics for the ring tap: three free-running wrapping counters.
module ring_tap_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_inc,
  input  logic             rx_inc,
  input  logic             drop_inc,
  output logic [CNT_W-1:0] tx_pkt_cnt,
  output logic [CNT_W-1:0] rx_pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_pkt_cnt <= '0;
      rx_pkt_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (tx_inc)   tx_pkt_cnt <= tx_pkt_cnt + 1'b1;
      if (rx_inc)   rx_pkt_cnt <= rx_pkt_cnt + 1'b1;
      if (drop_inc) drop_cnt   <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ring_tap_fair_fsm.sv
// Ring tap: injects local packets onto the ring, forwards/copies/sinks ring
// packets by destination vector, and bounds local bursts while ring traffic waits.
module ring_tap_fair_fsm
  import ring_tap_pkg::*;
#(
  parameter int RDP_SZ    = 65,
  parameter int PDP_SZ    = 64,
  parameter int NUM_PORTS = 4,
  parameter int PORTNUM   = 0,
  parameter int FAIR_LIM  = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lfli_srdy,
  input  logic [NUM_PORTS-1:0] lfli_data,
  output logic                 lfli_drdy,
  input  logic                 lprx_srdy,
  input  logic [PDP_SZ-1:0]    lprx_data,
  output logic                 lprx_drdy,
  output logic                 lptx_srdy,
  output logic [PDP_SZ-1:0]    lptx_data,
  input  logic                 lptx_drdy,
  input  logic                 lri_srdy,
  input  logic [RDP_SZ-1:0]    lri_data,
  output logic                 lri_drdy,
  output logic                 lro_srdy,
  output logic [RDP_SZ-1:0]    lro_data,
  input  logic                 lro_drdy,
  output logic                 rarb_req,
  input  logic                 rarb_ack,
  output logic [CNT_W-1:0]     tx_pkt_cnt,
  output logic [CNT_W-1:0]     rx_pkt_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 fair_hold
);

  localparam logic [NUM_PORTS-1:0] OWN_BIT = NUM_PORTS'(1) << PORTNUM;

  state_t               state, state_n;
  logic [7:0]           fair_cnt, fair_n;
  logic [NUM_PORTS-1:0] lvec, rvec;
  logic                 local_pend, local_go;
  logic                 lprx_end, lri_end;
  logic                 tx_inc, rx_inc, drop_inc;

  assign lvec       = lfli_data & ~OWN_BIT;
  assign rvec       = lri_data[NUM_PORTS-1:0] & ~OWN_BIT;
  assign local_pend = lfli_srdy & lprx_srdy;
  assign fair_hold  = (fair_cnt == 8'(FAIR_LIM));
  assign local_go   = local_pend & rarb_ack & ~fair_hold;
  assign lprx_end   = is_end_pcc(lprx_data[PDP_SZ-1 -: PCC_W]);
  assign lri_end    = is_end_pcc(lri_data[PDP_SZ-1 -: PCC_W]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      fair_cnt <= '0;
    end else begin
      state    <= state_n;
      fair_cnt <= fair_n;
    end
  end

  // Handshake outputs are gated by reset so they drop the instant it asserts.
  always_comb begin
    state_n   = state;
    fair_n    = fair_cnt;
    lfli_drdy = 1'b0;
    lprx_drdy = 1'b0;
    lptx_srdy = 1'b0;
    lri_drdy  = 1'b0;
    lro_srdy  = 1'b0;
    rarb_req  = 1'b0;
    lro_data  = lri_data;
    lptx_data = lri_data[PDP_SZ-1:0];
    tx_inc    = 1'b0;
    rx_inc    = 1'b0;
    drop_inc  = 1'b0;
    if (!reset) begin
      case (state)
        S_IDLE: begin
          rarb_req = local_pend & ~fair_hold;
          if (local_go) begin
            if (lvec == '0) begin
              lfli_drdy = 1'b1;
              state_n   = S_TDROP;
              fair_n    = lri_srdy ? fair_cnt + 8'd1 : '0;
            end else begin
              lro_data                  = '0;
              lro_data[RDP_SZ-1]        = 1'b1;
              lro_data[NUM_PORTS-1:0]   = lvec;
              if (lro_drdy) begin
                lro_srdy  = 1'b1;
                lfli_drdy = 1'b1;
                state_n   = S_TDATA;
                fair_n    = lri_srdy ? fair_cnt + 8'd1 : '0;
              end
            end
          end else if (lri_srdy) begin
            if (!lri_data[PORTNUM]) begin
              if (lro_drdy) begin
                lro_srdy = 1'b1;
                lri_drdy = 1'b1;
                state_n  = S_RFWD;
                fair_n   = '0;
              end
            end else if (rvec != '0) begin
              lro_data                = '0;
              lro_data[RDP_SZ-1]      = 1'b1;
              lro_data[NUM_PORTS-1:0] = rvec;
              if (lro_drdy) begin
                lro_srdy = 1'b1;
                lri_drdy = 1'b1;
                state_n  = S_RCOPY;
                fair_n   = '0;
              end
            end else begin
              lri_drdy = 1'b1;
              state_n  = S_RSINK;
              fair_n   = '0;
            end
          end
        end
        S_TDATA: begin
          rarb_req = 1'b1;
          lro_data = RDP_SZ'({1'b0, lprx_data});
          if (lprx_srdy && lro_drdy) begin
            lro_srdy  = 1'b1;
            lprx_drdy = 1'b1;
            if (lprx_end) begin
              state_n = S_IDLE;
              tx_inc  = 1'b1;
            end
          end
        end
        S_TDROP: begin
          lprx_drdy = 1'b1;
          if (lprx_srdy && lprx_end) begin
            state_n  = S_IDLE;
            drop_inc = 1'b1;
          end
        end
        S_RFWD: begin
          if (lri_srdy && lro_drdy) begin
            lro_srdy = 1'b1;
            lri_drdy = 1'b1;
            if (lri_end) state_n = S_IDLE;
          end
        end
        S_RSINK: begin
          if (lri_srdy && lptx_drdy) begin
            lptx_srdy = 1'b1;
            lri_drdy  = 1'b1;
            if (lri_end) begin
              state_n = S_IDLE;
              rx_inc  = 1'b1;
            end
          end
        end
        S_RCOPY: begin
          if (lri_srdy && lro_drdy && lptx_drdy) begin
            lro_srdy  = 1'b1;
            lptx_srdy = 1'b1;
            lri_drdy  = 1'b1;
            if (lri_end) begin
              state_n = S_IDLE;
              rx_inc  = 1'b1;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  ring_tap_stats #(.CNT_W(CNT_W)) u_stats (
    .clk        (clk),
    .reset      (reset),
    .tx_inc     (tx_inc),
    .rx_inc     (rx_inc),
    .drop_inc   (drop_inc),
    .tx_pkt_cnt (tx_pkt_cnt),
    .rx_pkt_cnt (rx_pkt_cnt),
    .drop_cnt   (drop_cnt)
  );

endmodule

// File: tb/tb_ring_tap_fair_fsm.sv
// Scoreboard bench for ring_tap_fair_fsm at PORTNUM=1, NUM_PORTS=4, FAIR_LIM=2.
module tb_ring_tap_fair_fsm;
  import ring_tap_pkg::*;

  localparam logic [3:0] OWN = 4'b0010;

  logic        clk = 1'b0;
  logic        reset;
  logic        lfli_srdy, lfli_drdy;
  logic [3:0]  lfli_data;
  logic        lprx_srdy, lprx_drdy;
  logic [63:0] lprx_data;
  logic        lptx_srdy, lptx_drdy;
  logic [63:0] lptx_data;
  logic        lri_srdy, lri_drdy;
  logic [64:0] lri_data;
  logic        lro_srdy, lro_drdy;
  logic [64:0] lro_data;
  logic        rarb_req, rarb_ack;
  logic [15:0] tx_pkt_cnt, rx_pkt_cnt, drop_cnt;
  logic        fair_hold;

  logic [64:0] lro_exp[$];
  logic [63:0] lptx_exp[$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_tx = 0, exp_rx = 0, exp_drop = 0;

  ring_tap_fair_fsm #(
    .RDP_SZ(65), .PDP_SZ(64), .NUM_PORTS(4), .PORTNUM(1), .FAIR_LIM(2), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .lfli_srdy(lfli_srdy), .lfli_data(lfli_data), .lfli_drdy(lfli_drdy),
    .lprx_srdy(lprx_srdy), .lprx_data(lprx_data), .lprx_drdy(lprx_drdy),
    .lptx_srdy(lptx_srdy), .lptx_data(lptx_data), .lptx_drdy(lptx_drdy),
    .lri_srdy(lri_srdy), .lri_data(lri_data), .lri_drdy(lri_drdy),
    .lro_srdy(lro_srdy), .lro_data(lro_data), .lro_drdy(lro_drdy),
    .rarb_req(rarb_req), .rarb_ack(rarb_ack),
    .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt), .drop_cnt(drop_cnt),
    .fair_hold(fair_hold)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pkt_word(input int seed, input int i, input int n, input bit bad);
    logic [1:0] pcc;
    if (i == n - 1)  pcc = bad ? PCC_BADEOP : PCC_EOP;
    else if (i == 0) pcc = PCC_SOP;
    else             pcc = PCC_DATA;
    return {pcc, 30'(seed * 977 + i), 32'(seed) ^ 32'(i << 12) ^ 32'h5A5A_0000};
  endfunction

  function automatic logic [64:0] pvec_word(input logic [3:0] v);
    logic [64:0] w;
    w      = '0;
    w[64]  = 1'b1;
    w[3:0] = v;
    return w;
  endfunction

  task automatic push_ring_exp(input logic [3:0] pvec, input int seed, input int n);
    logic [3:0] rv;
    rv = pvec & ~OWN;
    if (pvec[1] == 1'b0) begin
      lro_exp.push_back(pvec_word(pvec));
      for (int i = 0; i < n; i++) lro_exp.push_back({1'b0, pkt_word(seed, i, n, 1'b0)});
    end else begin
      exp_rx++;
      if (rv != 4'b0) lro_exp.push_back(pvec_word(rv));
      for (int i = 0; i < n; i++) begin
        if (rv != 4'b0) lro_exp.push_back({1'b0, pkt_word(seed, i, n, 1'b0)});
        lptx_exp.push_back(pkt_word(seed, i, n, 1'b0));
      end
    end
  endtask

  task automatic check_stats(input string tag);
    check_val({tag, "_tx"},   tx_pkt_cnt, exp_tx);
    check_val({tag, "_rx"},   rx_pkt_cnt, exp_rx);
    check_val({tag, "_drop"}, drop_cnt,   exp_drop);
  endtask

  task automatic run_local(input logic [3:0] vec, input int seed, input int n, input bit bad);
    logic [3:0] lv;
    int idx, budget;
    bit fli_done, fx, px;
    lv = vec & ~OWN;
    if (lv != 4'b0) begin
      lro_exp.push_back(pvec_word(lv));
      for (int i = 0; i < n; i++) lro_exp.push_back({1'b0, pkt_word(seed, i, n, bad)});
      exp_tx++;
    end else begin
      exp_drop++;
    end
    idx = 0; budget = 60; fli_done = 1'b0;
    lfli_srdy = 1'b1; lfli_data = vec;
    lprx_srdy = 1'b1; lprx_data = pkt_word(seed, 0, n, bad);
    rarb_ack  = 1'b1;
    while ((idx < n || !fli_done) && budget > 0) begin
      @(negedge clk);
      fx = lfli_srdy & lfli_drdy;
      px = lprx_srdy & lprx_drdy;
      @(posedge clk); #1;
      budget--;
      if (fx) begin fli_done = 1'b1; lfli_srdy = 1'b0; end
      if (px) begin
        idx++;
        if (idx < n) lprx_data = pkt_word(seed, idx, n, bad);
        else         lprx_srdy = 1'b0;
      end
    end
    check_val("local_words", idx, n);
    check_val("local_fib", fli_done, 1);
  endtask

  task automatic run_ring(input logic [3:0] pvec, input int seed, input int n, input bit stall, input bit push);
    int idx, budget, stall_left;
    bit rx;
    if (push) push_ring_exp(pvec, seed, n);
    idx = -1; budget = 80; stall_left = 0;
    lri_srdy = 1'b1; lri_data = pvec_word(pvec);
    while (idx < n && budget > 0) begin
      @(negedge clk);
      if (stall_left > 0) begin
        check_val("stall_lro_srdy", lro_srdy, 0);
        check_val("stall_lri_drdy", lri_drdy, 0);
      end
      rx = lri_srdy & lri_drdy;
      @(posedge clk); #1;
      budget--;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) lptx_drdy = 1'b1;
      end
      if (rx) begin
        idx++;
        if (idx < n) lri_data = {1'b0, pkt_word(seed, idx, n, 1'b0)};
        else         lri_srdy = 1'b0;
        if (stall && idx == 1) begin lptx_drdy = 1'b0; stall_left = 2; end
      end
    end
    check_val("ring_words", idx, n);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (lro_srdy && lro_drdy) begin
        if (lro_exp.size() == 0) check_val("lro_q_nonempty", lro_exp.size(), 1);
        else                     check_val("lro_word", lro_data, lro_exp.pop_front());
      end
      if (lptx_srdy && lptx_drdy) begin
        if (lptx_exp.size() == 0) check_val("lptx_q_nonempty", lptx_exp.size(), 1);
        else                      check_val("lptx_word", lptx_data, lptx_exp.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded", $time);
    $fatal(1);
  end

  initial begin
    logic [63:0] w0;
    reset = 1'b1;
    lfli_srdy = 1'b1; lfli_data = 4'b0100;
    lprx_srdy = 1'b1; lprx_data = '0;
    lri_srdy = 1'b1;  lri_data = pvec_word(4'b0010);
    lro_drdy = 1'b1;  lptx_drdy = 1'b1; rarb_ack = 1'b1;
    #12;
    check_val("rst_lfli_drdy", lfli_drdy, 0);
    check_val("rst_lprx_drdy", lprx_drdy, 0);
    check_val("rst_lri_drdy",  lri_drdy, 0);
    check_val("rst_lro_srdy",  lro_srdy, 0);
    check_val("rst_lptx_srdy", lptx_srdy, 0);
    check_val("rst_fair_hold", fair_hold, 0);
    check_stats("rst");
    lfli_srdy = 1'b0; lprx_srdy = 1'b0; lri_srdy = 1'b0; rarb_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Local pending without arbitration ack: request raised, nothing consumed.
    lfli_srdy = 1'b1; lfli_data = 4'b0100;
    lprx_srdy = 1'b1; lprx_data = pkt_word(1, 0, 3, 1'b0);
    #1;
    check_val("noack_rarb_req",  rarb_req, 1);
    check_val("noack_lfli_drdy", lfli_drdy, 0);
    check_val("noack_lro_srdy",  lro_srdy, 0);
    run_local(4'b0100, 1, 3, 1'b0);
    check_stats("tx1");
    run_local(4'b0010, 2, 3, 1'b0);
    check_stats("drop1");
    run_local(4'b1111, 3, 2, 1'b1);
    check_stats("tx_badeop");

    run_ring(4'b1010, 4, 3, 1'b1, 1'b1);
    check_stats("rcopy");
    run_ring(4'b0101, 5, 3, 1'b0, 1'b1);
    check_stats("rfwd");
    run_ring(4'b0010, 6, 2, 1'b0, 1'b1);
    check_stats("rsink");

    // Two local packets win while ring waits; the third is held off by fairness.
    fork
      run_ring(4'b0001, 9, 3, 1'b0, 1'b0);
      begin
        run_local(4'b0100, 10, 3, 1'b0);
        check_val("fair_hold_after1", fair_hold, 0);
        run_local(4'b1000, 11, 2, 1'b0);
        check_val("fair_hold_after2", fair_hold, 1);
        push_ring_exp(4'b0001, 9, 3);
        lfli_srdy = 1'b1; lfli_data = 4'b0100;
        lprx_srdy = 1'b1; lprx_data = pkt_word(12, 0, 2, 1'b0);
        #1;
        check_val("fair_rarb_req", rarb_req, 0);
        check_val("fair_lri_drdy", lri_drdy, 1);
        @(posedge clk); #1;
        check_val("fair_hold_clear", fair_hold, 0);
        run_local(4'b0100, 12, 2, 1'b0);
      end
    join
    check_stats("fair");
    check_val("lro_q_drained1",  lro_exp.size(), 0);
    check_val("lptx_q_drained1", lptx_exp.size(), 0);

    // Reset in the middle of a copied ring packet.
    w0 = pkt_word(30, 0, 3, 1'b0);
    lro_exp.push_back(pvec_word(4'b0100));
    lro_exp.push_back({1'b0, w0});
    lptx_exp.push_back(w0);
    lri_srdy = 1'b1; lri_data = pvec_word(4'b0110);
    @(posedge clk); #1;
    lri_data = {1'b0, w0};
    @(posedge clk); #1;
    lri_data = {1'b0, pkt_word(30, 1, 3, 1'b0)};
    check_val("rcopy_mid_lri_drdy", lri_drdy, 1);
    reset = 1'b1;
    exp_tx = 0; exp_rx = 0; exp_drop = 0;
    #1;
    check_val("midrst_lri_drdy",  lri_drdy, 0);
    check_val("midrst_lro_srdy",  lro_srdy, 0);
    check_val("midrst_lptx_srdy", lptx_srdy, 0);
    check_val("midrst_lfli_drdy", lfli_drdy, 0);
    check_val("midrst_lprx_drdy", lprx_drdy, 0);
    check_val("midrst_fair_hold", fair_hold, 0);
    check_stats("midrst");
    lri_srdy = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_local(4'b1000, 20, 2, 1'b0);
    run_ring(4'b0110, 21, 2, 1'b0, 1'b1);
    check_stats("post_rst");
    check_val("lro_q_drained2",  lro_exp.size(), 0);
    check_val("lptx_q_drained2", lptx_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ring_tap_fair_fsm.md
RING_TAP_FAIR_FSM -- requirements
Module: ring_tap_fair_fsm

Interface
REQ-001 Parameter RDP_SZ, default 65: ring word width; SHALL equal PDP_SZ+1.
REQ-002 Parameter PDP_SZ, default 64: port data word width.
REQ-003 Parameter NUM_PORTS, default 4: number of ring ports, 2..16.
REQ-004 Parameter PORTNUM, default 0: this tap's port index, 0..NUM_PORTS-1.
REQ-005 Parameter FAIR_LIM, default 4: max consecutive local packets while ring traffic waits, 1..255.
REQ-006 Parameter CNT_W, default 16: statistics counter width.
REQ-007 clk  in  1  single clock; reset  in  1  asynchronous, active-high.
REQ-008 lfli_srdy in 1 / lfli_data in NUM_PORTS / lfli_drdy out 1: FIB lookup result (destination vector).
REQ-009 lprx_srdy in 1 / lprx_data in PDP_SZ / lprx_drdy out 1: local receive packet data.
REQ-010 lptx_srdy out 1 / lptx_data out PDP_SZ / lptx_drdy in 1: local transmit packet data.
REQ-011 lri_srdy in 1 / lri_data in RDP_SZ / lri_drdy out 1: ring input.
REQ-012 lro_srdy out 1 / lro_data out RDP_SZ / lro_drdy in 1: ring output.
REQ-013 rarb_req out 1 / rarb_ack in 1: ring injection arbitration.
REQ-014 tx_pkt_cnt, rx_pkt_cnt, drop_cnt out CNT_W each; fair_hold out 1: statistics, fairness-hold status.

Function
REQ-015 Ring word: bit RDP_SZ-1 = PVEC flag; PVEC word carries destination vector in bits [NUM_PORTS-1:0], other bits 0; data word bits [PDP_SZ-1:PDP_SZ-2] = PCC (DATA=0, SOP=1, EOP=2, BADEOP=3); "end word" = PCC EOP or BADEOP.
REQ-016 All handshakes combinational, zero latency; a transfer occurs when srdy&drdy in the same cycle.
REQ-017 One-hot states IDLE, TDATA, TDROP, RFWD, RCOPY, RSINK; illegal encoding -> IDLE next cycle.
REQ-018 lvec = lfli_data & ~(1<<PORTNUM) (own bit removed, no loopback); rvec = lri_data[NUM_PORTS-1:0] & ~(1<<PORTNUM).
REQ-019 local_pend = lfli_srdy & lprx_srdy; rarb_req = (local_pend & ~fair_hold & IDLE) | TDATA.
REQ-020 IDLE, local_pend & rarb_ack & ~fair_hold: lvec==0 -> lfli_drdy=1, go TDROP; lvec!=0 -> drive PVEC word with lvec, on lro_drdy assert lro_srdy, lfli_drdy, go TDATA.
REQ-021 IDLE, else lri_srdy (PVEC word): own bit clear -> on lro_drdy forward word, lri_drdy=1, go RFWD; own bit set & rvec!=0 -> on lro_drdy forward with data bits replaced by rvec, go RCOPY; own bit set & rvec==0 -> lri_drdy=1, go RSINK.
REQ-022 Local has priority in IDLE when both eligible; fair_hold removes local eligibility.
REQ-023 TDATA: lro_data = {0,lprx_data}; transfer on lprx_srdy&lro_drdy; end word -> IDLE.
REQ-024 TDROP: lprx_drdy=1; end word accepted -> IDLE.
REQ-025 RFWD: lri->lro passthrough; RSINK: lri->lptx (low PDP_SZ bits); RCOPY: lri->lro and lptx, transfer only when lri_srdy&lro_drdy&lptx_drdy; end word -> IDLE.
REQ-026 fair_cnt (8 bit): +1 when IDLE starts local packet (TDATA or TDROP) while lri_srdy=1; cleared when IDLE accepts a ring PVEC word or when IDLE starts local with lri_srdy=0.
REQ-027 fair_hold = (fair_cnt == FAIR_LIM); held until next ring PVEC accepted.
REQ-028 tx_pkt_cnt +1 on TDATA end-word transfer; rx_pkt_cnt +1 on RCOPY/RSINK end-word transfer; drop_cnt +1 on TDROP end-word accept; all wrap modulo 2^CNT_W.
REQ-029 Outputs lfli_drdy, lprx_drdy, lptx_srdy, lri_drdy, lro_srdy SHALL be 0 whenever no transfer condition in REQ-020..025 holds.

Reset
REQ-030 reset asserted: state=IDLE, fair_cnt=0, all counters=0, fair_hold=0, all srdy/drdy outputs 0 immediately (asynchronous).
REQ-031 Reset mid-packet abandons packet; no partial-packet recovery; counters not incremented.

Structure
REQ-032 Package ring_tap_pkg: PCC codes, PVEC bit position, PCC field position, state index constants.
REQ-033 Sub-module ring_tap_stats: three wrapping CNT_W counters with increment strobes.

Verification
REQ-034 PORTNUM=1, lfli_data=4'b0100, 3-word packet (SOP,DATA,EOP) -> lro PVEC word 0x1_..._04, then 3 data words PVEC=0, tx_pkt_cnt=1.
REQ-035 lfli_data=4'b0010 (own bit only) -> no lro_srdy, 3 words drained, drop_cnt=1, back to IDLE.
REQ-036 Ring PVEC 4'b1010 at PORTNUM=1 -> lro PVEC 4'b1000, packet copied to lptx and lro, rx_pkt_cnt=1; lptx_drdy=0 for 2 cycles stalls both.
REQ-037 FAIR_LIM=2, local packets back-to-back with lri_srdy held -> after 2 local packets fair_hold=1, rarb_req=0, ring packet accepted next, fair_hold=0.
REQ-038 Reset asserted during RCOPY mid-packet -> all srdy/drdy 0 same cycle, state IDLE, counters 0.
